// File: rtl/read_chan_mngr_multi_if.sv
// Bus-side signals of the multi-outstanding read manager: request/grant,
// AR address channel and R data channel.
interface read_chan_mngr_multi_if #(
    parameter int DW = 32
);
    logic          req_rq;
    logic          gnt_rq;
    logic          arvalid;
    logic          arready;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic          rvalid;
    logic          rready;
    logic [3:0]    rid;
    logic [DW-1:0] rdata;
    logic          rlast;

    modport master (
        output req_rq, arvalid, arid, araddr, arlen, rready,
        input  gnt_rq, arready, rvalid, rid, rdata, rlast
    );

    modport slave (
        input  req_rq, arvalid, arid, araddr, arlen, rready,
        output gnt_rq, arready, rvalid, rid, rdata, rlast
    );
endinterface

// File: rtl/read_chan_mngr_multi.sv
// Multi-outstanding read manager: issues bursts into per-ID slots, reassembles
// out-of-order R beats into lines and hands finished lines to the read queue.
module read_chan_mngr_multi #(
    parameter logic [1:0] REQC_M_ID = 2'b00,
    parameter int         DW        = 32,
    parameter int         BEATS     = 4,
    parameter int         OUTS      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    read_chan_mngr_multi_if.master bus,
    input  logic                  rstart_rq,
    input  logic [31:0]           rin_addr,
    output logic                  raccept,
    output logic                  rnext_rq,
    output logic [3:0]            rnext_id,
    input  logic                  rqfull_1,
    output logic [BEATS*DW-1:0]   rdat_m_data,
    output logic                  rdat_m_valid,
    output logic [3:0]            rdat_m_id,
    output logic                  finish_mrd,
    output logic                  rid_err
);
    localparam int CW = $clog2(BEATS + 1);
    localparam int LW = BEATS * DW;

    typedef enum logic [1:0] {S_FREE, S_REQ, S_WAIT, S_DONE} slot_st_e;
    typedef enum logic [1:0] {AR_IDLE, AR_ARB, AR_ADDR} ar_st_e;

    slot_st_e      slot_st   [OUTS];
    logic [31:0]   slot_addr [OUTS];
    logic [CW-1:0] slot_cnt  [OUTS];
    logic [LW-1:0] slot_buf  [OUTS];

    ar_st_e        ar_st, ar_nxt;
    logic [3:0]    ar_id_q;
    logic [31:0]   ar_addr_q;

    logic          any_free, any_req, any_done, beat_hit;
    logic [1:0]    free_idx, req_idx, done_idx, beat_idx;
    logic [31:0]   req_addr;
    logic [LW-1:0] done_line;
    logic [CW-1:0] beat_cnt;
    logic          beat_room, alloc, ar_fire, deliver, err_evt;

    // Descending scan so the lowest-index match wins.
    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        any_free  = 1'b0;
        any_req   = 1'b0;
        any_done  = 1'b0;
        beat_hit  = 1'b0;
        free_idx  = '0;
        req_idx   = '0;
        done_idx  = '0;
        beat_idx  = '0;
        req_addr  = '0;
        done_line = '0;
        beat_cnt  = '0;
        for (int i = OUTS - 1; i >= 0; i--) begin
            if (slot_st[i] == S_FREE) begin
                any_free = 1'b1;
                free_idx = 2'(i);
            end
            if (slot_st[i] == S_REQ) begin
                any_req  = 1'b1;
                req_idx  = 2'(i);
                req_addr = slot_addr[i];
            end
            if (slot_st[i] == S_DONE) begin
                any_done  = 1'b1;
                done_idx  = 2'(i);
                done_line = slot_buf[i];
            end
            if (bus.rvalid && bus.rid[3:2] == REQC_M_ID && bus.rid[1:0] == 2'(i)
                && slot_st[i] == S_WAIT) begin
                beat_hit = 1'b1;
                beat_idx = 2'(i);
                beat_cnt = slot_cnt[i];
            end
        end
    end

    assign raccept   = any_free && !rst;
    assign alloc     = rstart_rq && raccept;
    assign ar_fire   = (ar_st == AR_ADDR) && bus.arready;
    assign deliver   = !rqfull_1 && any_done;
    assign beat_room = beat_cnt < CW'(BEATS);

    // Errors: start refused, beat for no waiting slot, overflow beat, short burst.
    assign err_evt = (rstart_rq && !raccept)
                   || (bus.rvalid && !beat_hit)
                   || (beat_hit && !beat_room)
                   || (beat_hit && beat_room && bus.rlast && beat_cnt < CW'(BEATS - 1));

    assign rnext_rq   = ar_fire;
    assign rnext_id   = ar_fire ? ar_id_q : 4'h0;
    assign bus.arid   = ar_id_q;
    assign bus.araddr = ar_addr_q;
    assign bus.arlen  = 8'(BEATS - 1);
    assign bus.rready = !rst;

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment.
        if (rst) ar_st <= AR_IDLE;
        else     ar_st <= ar_nxt;
    end

    always_comb begin
        ar_nxt      = ar_st;
        bus.req_rq  = 1'b0;
        bus.arvalid = 1'b0;
        unique case (ar_st)
            AR_IDLE: if (any_req) ar_nxt = AR_ARB;
            AR_ARB: begin
                bus.req_rq = 1'b1;
                if (bus.gnt_rq) ar_nxt = AR_ADDR;
            end
            AR_ADDR: begin
                // Grant loss here is ignored: arvalid must not drop once raised.
                bus.req_rq  = 1'b1;
                bus.arvalid = 1'b1;
                if (bus.arready) ar_nxt = AR_IDLE;
            end
            default: ar_nxt = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_id_q      <= '0;
            ar_addr_q    <= '0;
            rdat_m_data  <= '0;
            rdat_m_valid <= 1'b0;
            rdat_m_id    <= '0;
            finish_mrd   <= 1'b0;
            rid_err      <= 1'b0;
            for (int i = 0; i < OUTS; i++) slot_st[i] <= S_FREE;
        end else begin
            if (ar_st == AR_IDLE && any_req) begin
                ar_id_q   <= {REQC_M_ID, req_idx};
                ar_addr_q <= req_addr;
            end
            rdat_m_valid <= deliver;
            finish_mrd   <= deliver;
            if (deliver) begin
                rdat_m_data <= done_line;
                rdat_m_id   <= {REQC_M_ID, done_idx};
            end
            if (err_evt) rid_err <= 1'b1;
            // Each event needs a different slot state, so they never collide.
            for (int i = 0; i < OUTS; i++) begin
                if (alloc && free_idx == 2'(i))                      slot_st[i] <= S_REQ;
                if (ar_fire && ar_id_q[1:0] == 2'(i))                slot_st[i] <= S_WAIT;
                if (beat_hit && beat_idx == 2'(i) && bus.rlast)      slot_st[i] <= S_DONE;
                if (deliver && done_idx == 2'(i))                    slot_st[i] <= S_FREE;
            end
        end
    end

    // NOTE: slot storage has no reset; allocation clears it before any use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTS; i++) begin
            if (alloc && free_idx == 2'(i)) begin
                slot_addr[i] <= rin_addr;
                slot_cnt[i]  <= '0;
                slot_buf[i]  <= '0;
            end else if (beat_hit && beat_room && beat_idx == 2'(i)) begin
                slot_cnt[i] <= slot_cnt[i] + 1'b1;
                for (int b = 0; b < BEATS; b++) begin
                    if (slot_cnt[i] == CW'(b)) slot_buf[i][b*DW +: DW] <= bus.rdata;
                end
            end
        end
    end
endmodule

// File: doc/read_chan_mngr_multi.md
Name: read_chan_mngr_multi

Overview:
- Parametrised successor of the single-outstanding read manager.
- Issues AXI-style read bursts (AR channel, gated by bus request/grant) on behalf of a front-end requester.
- Tracks up to OUTS outstanding bursts in per-ID slots and reassembles out-of-order R beats into BEATS*DW-bit lines.
- Delivers completed lines to the downstream read queue, honouring its full flag.

Parameters:
REQC_M_ID, 2'b00, master ID; forms upper 2 bits of arid.
DW, 32, R/AR data width in bits.
BEATS, 4, beats per burst (2..16); arlen = BEATS-1.
OUTS, 4, outstanding slots (1..4); slot index forms lower 2 bits of arid.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_rq  out  1  bus request
gnt_rq  in  1  bus grant
arvalid  out  1  read address valid
arready  in  1  read address ready
arid  out  4  {REQC_M_ID, slot}
araddr  out  32  burst start address
arlen  out  8  BEATS-1
rvalid  in  1  read data valid
rready  out  1  read data ready
rid  in  4  read data ID
rdata  in  DW  read data beat
rlast  in  1  last beat
rstart_rq  in  1  front-end read start pulse
rin_addr  in  32  start address, sampled with rstart_rq
raccept  out  1  free slot exists; rstart_rq honoured only when high
rnext_rq  out  1  one-cycle pulse on AR handshake
rnext_id  out  4  ID issued with rnext_rq
rqfull_1  in  1  downstream queue full
rdat_m_data  out  BEATS*DW  assembled line, beat 0 in LSBs
rdat_m_valid  out  1  one-cycle line-valid pulse
rdat_m_id  out  4  ID of delivered line
finish_mrd  out  1  pulse coincident with rdat_m_valid
rid_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: all slots FREE, AR FSM IDLE. All outputs 0, except arlen = BEATS-1 (constant).
- Slot states: FREE -> REQ -> WAIT -> DONE -> FREE. Per-slot storage: address, beat counter, line buffer.
- raccept: combinational, = any slot FREE, evaluated on current-cycle state.
  - A slot freed by delivery is reusable from the next cycle only.
- Allocation: rstart_rq && raccept -> lowest-index FREE slot becomes REQ next cycle; rin_addr stored; line buffer and beat counter cleared.
  - rstart_rq with raccept=0 is ignored and sets rid_err.
- AR FSM:
  - IDLE: any slot in REQ -> latch lowest-index REQ slot, go ARB.
  - ARB: req_rq=1; on gnt_rq go ADDR.
  - ADDR: arvalid=1, req_rq=1; arid/araddr held stable until arready. Loss of gnt_rq in ADDR does not drop arvalid.
  - On arvalid&&arready: slot -> WAIT, rnext_rq pulses with rnext_id=arid, return to IDLE (req_rq=0 that cycle edge).
  - Minimum 3 cycles between successive AR handshakes.
- R channel:
  - rready is 1 whenever not in reset; all beats are always accepted.
  - A beat is valid when rid[3:2]==REQC_M_ID and slot rid[1:0] < OUTS is in WAIT. Valid beats write the slot buffer at [cnt*DW +: DW] and increment cnt.
  - Invalid beat: discarded, rid_err set.
  - rlast on a valid beat -> slot DONE next cycle.
  - rlast with cnt < BEATS-1: DONE anyway; unwritten beats stay 0; rid_err set.
  - Beat arriving with cnt == BEATS-1 but no rlast: written, counter saturates, slot stays WAIT. Further beats are discarded and set rid_err until rlast.
- Delivery:
  - When rqfull_1=0 and any slot is DONE, the lowest-index DONE slot is registered to rdat_m_data/rdat_m_id, rdat_m_valid=finish_mrd=1 for one cycle, and the slot becomes FREE.
  - rqfull_1=1: no delivery; DONE slots hold indefinitely.
  - rdat_m_data holds its last value between pulses.
- Latency: rlast beat accepted at cycle N -> slot DONE at N+1 -> rdat_m_valid at N+2 (if rqfull_1=0).
- Simultaneous events: allocation, AR handshake, R beat and delivery may all occur in one cycle on different slots without interaction.
- rid_err clears only on rst.
- rst mid-operation: all slots and in-flight bursts abandoned. Later beats for stale IDs arriving after reset set rid_err.

Test Plan:
- Single read, defaults, rin_addr=0x1000, gnt/arready immediate, beats 0x11,0x22,0x33,0x44 -> arid=0x0, araddr=0x1000, arlen=3; rdat_m_data=0x00000044_00000033_00000022_00000011, rdat_m_id=0x0, valid 2 cycles after rlast.
- Four starts back-to-back (0x100,0x200,0x300,0x400) -> raccept=0 after 4th; arid 0,1,2,3 in order. R returns IDs 2,0,3,1 interleaved beat-by-beat -> lines delivered in completion order, each correct.
- rqfull_1 held 1 while slots 1 and 3 complete, then released -> slot 1 delivered first, slot 3 next cycle; no data loss.
- arvalid held 5 cycles with arready=0 and gnt_rq dropped after 1 -> arvalid, arid, araddr stable; single rnext_rq pulse on handshake.
- Beat with rid=0x4 (foreign master) and rlast after 2 beats on ID 0 -> foreign beat discarded; line=0x0..0_00000022_00000011; rid_err=1 until rst.
- rst asserted mid-burst with 2 slots WAIT -> all outputs 0, raccept=1 next cycle; new read completes normally.
